// File: rtl/spi_pkg.sv
// Shared SPI definitions for the mode-2 link: bus mode, idle pin levels and
// the receiver state encoding.
package spi_pkg;

  localparam logic CPOL = 1'b1;
  localparam logic CPHA = 1'b0;

  // Idle pin levels, shared with the master TX block.
  localparam logic SCLK_IDLE = CPOL;
  localparam logic CS_IDLE   = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchroniser for one asynchronous SPI pin: two metastability
// stages plus a delay stage that provides the previous value for edge detection.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] stg;

  always_ff @(posedge clk) begin
    if (rst) stg <= {3{RST_VAL}};
    else     stg <= {stg[1:0], din};
  end

  assign sync = stg[1];
  assign rise = stg[1] & ~stg[2];
  assign fall = ~stg[1] & stg[2];

endmodule

// File: rtl/spi_slave_rx_mode2.sv
// SPI mode-2 (CPOL=1, CPHA=0) slave receiver, MSB first, oversampled in the
// system clock domain; emits a valid strobe per word and flags truncated frames.
module spi_slave_rx_mode2
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  In_clk,
  input  logic                  In_rst,
  input  logic                  In_spi_cs_n,
  input  logic                  In_spi_sclk,
  input  logic                  In_spi_mosi,
  output logic [DATA_WIDTH-1:0] Out_rx_data,
  output logic                  Out_rx_valid,
  output logic                  Out_frame_err,
  output logic                  Out_busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic cs_rise, cs_fall, sclk_fall, mosi_sync;
  logic cs_sync_unused, sclk_sync_unused, sclk_rise_unused;
  logic mosi_rise_unused, mosi_fall_unused;

  // CS stages reset to asserted so a CS already low at reset release is not
  // mistaken for the start of a frame.
  spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
    .clk(In_clk), .rst(In_rst), .din(In_spi_cs_n),
    .sync(cs_sync_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(SCLK_IDLE)) u_sclk_sync (
    .clk(In_clk), .rst(In_rst), .din(In_spi_sclk),
    .sync(sclk_sync_unused), .rise(sclk_rise_unused), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(In_clk), .rst(In_rst), .din(In_spi_mosi),
    .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_t state, state_nx;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  start, shift_en, word_done, frame_err_nx;

  always_ff @(posedge In_clk) begin
    if (In_rst) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // CS rising takes priority over a coincident SCLK fall, so the error check
  // sees the bit count from before that edge.
  always_comb begin
    state_nx     = state;
    start        = 1'b0;
    shift_en     = 1'b0;
    word_done    = 1'b0;
    frame_err_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_nx = ST_RECV;
          start    = 1'b1;
        end
      end
      ST_RECV: begin
        if (cs_rise) begin
          state_nx     = ST_IDLE;
          frame_err_nx = (bit_cnt != '0);
        end else if (sclk_fall) begin
          shift_en  = 1'b1;
          word_done = (bit_cnt == LAST_BIT);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge In_clk) begin
    if (In_rst) begin
      bit_cnt       <= '0;
      shreg         <= '0;
      Out_rx_data   <= '0;
      Out_rx_valid  <= 1'b0;
      Out_frame_err <= 1'b0;
    end else begin
      Out_rx_valid  <= word_done;
      Out_frame_err <= frame_err_nx;
      if (start) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (shift_en) begin
        shreg <= {shreg[DATA_WIDTH-2:0], mosi_sync};
        if (word_done) begin
          Out_rx_data <= {shreg[DATA_WIDTH-2:0], mosi_sync};
          bit_cnt     <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign Out_busy = (state == ST_RECV);

endmodule

// File: doc/spi_slave_rx_mode2.md
# spi_slave_rx_mode2

SPI slave receiver for mode 2 (CPOL=1, CPHA=0), MSB first, with the SPI pins oversampled in the system clock domain. It is the far end of the SPI master transmit path. It deserialises MOSI into parallel words and emits a one-cycle valid strobe per completed word. It also flags frames that chip-select terminates mid-word.

## Interface
- DATA_WIDTH, 8, bits per word; range 2..32.
- In_clk  input  1  system clock; must be ≥ 8× SCLK frequency (50 MHz vs 50 kHz nominal).
- In_rst  input  1  synchronous, active-high reset.
- In_spi_cs_n  input  1  chip select from master, active low, asynchronous to In_clk.
- In_spi_sclk  input  1  SPI clock from master, idle high, asynchronous.
- In_spi_mosi  input  1  serial data, changed by master on SCLK rising edge.
- Out_rx_data  output  DATA_WIDTH  last completed word; holds until the next word completes.
- Out_rx_valid  output  1  one-cycle pulse when Out_rx_data is updated.
- Out_frame_err  output  1  one-cycle pulse when CS deasserts with a partial word.
- Out_busy  output  1  high while state is RECV.

## Operation
- **Input conditioning**
  - Each SPI input passes through a 2-FF synchroniser, then a third delay FF.
  - Edge detection compares stage 2 (current) against stage 3 (previous).
  - MOSI uses the same depth, so its stage-2 value aligns with the SCLK edge detect.
- **Synchroniser reset values**
  - cs stages reset to 0 (asserted). If CS is already low at reset release, no falling edge is seen; the block waits in IDLE until CS goes high and then low again.
  - sclk stages reset to 1.
  - mosi stages reset to 0.
- **FSM states: IDLE, RECV.**
  - IDLE → RECV on CS falling edge. Clear bit_cnt and the shift register.
  - In RECV, on each SCLK falling edge, shift in mosi: shreg = {shreg[DATA_WIDTH-2:0], mosi}, then bit_cnt+1.
  - When the shift completes bit DATA_WIDTH-1:
    - load Out_rx_data with the full word (including the bit just sampled);
    - pulse Out_rx_valid;
    - wrap bit_cnt to 0 and stay in RECV. Back-to-back words in one frame are supported with no gap required.
  - RECV → IDLE on CS rising edge. If bit_cnt ≠ 0, pulse Out_frame_err and discard the partial word; Out_rx_data is unchanged.
- **Filtering**
  - SCLK rising edges are not used.
  - SCLK edges seen in IDLE are ignored.
- **Simultaneous events**
  - CS rising and SCLK falling in the same cycle: CS wins. The edge is not shifted; the error check uses bit_cnt before the edge.
  - CS falling and SCLK falling in the same cycle: enter RECV, ignore that SCLK edge.
- **Width rules**
  - bit_cnt width is $clog2(DATA_WIDTH).
  - Full-word detection is bit_cnt == DATA_WIDTH-1 together with an edge; no counter overflow is used.
- **Reset mid-operation**
  - All state returns to IDLE immediately on the cycle In_rst is sampled high; the partial word is lost.
  - No frame_err is raised for the aborted frame.

## Timing
- Reset values:
  - Out_rx_data = 0
  - Out_rx_valid = 0
  - Out_frame_err = 0
  - Out_busy = 0
  - state = IDLE
  - bit_cnt = 0
- Pin-to-detect latency: a pin transition first captured on In_clk edge N appears in the edge detect during cycle N+2.
- Registered response to that edge lands at N+3. This applies to:
  - Out_rx_valid and Out_rx_data after the final SCLK falling edge of a word;
  - Out_frame_err and Out_busy falling after CS rising;
  - Out_busy rising after CS falling.
- Out_rx_valid and Out_frame_err are exactly one In_clk cycle wide and never high together.
- Minimum SCLK high and low time is 4 In_clk cycles. Shorter pulses are out of spec; behaviour is undefined but must not hang the FSM.
- CS falling to first SCLK falling must be ≥ 4 In_clk cycles.

## Structure
- **Package spi_pkg:**
  - state encoding constants ST_IDLE = 1'b0, ST_RECV = 1'b1;
  - CPOL = 1 and CPHA = 0 mode constants;
  - idle-level constants for SCLK and CS, shared with the master TX block.
- **Sub-module spi_sync_edge:**
  - 3-flop synchroniser with a parameterised reset value;
  - outputs sync, rise, fall;
  - instantiated once per SPI input.
- The top-level holds the FSM, bit counter, shift register and output registers.

## Test plan
- **Single word:** CS low, 8 mode-2 cycles at 50 kHz carrying 0xA5, CS high. Expect:
  - one Out_rx_valid, with Out_rx_data = 0xA5 at 3 cycles after the 8th SCLK fall;
  - no frame_err;
  - Out_busy high throughout the frame.
- **Back-to-back:** 0x3C then 0xC3 in one frame with no gap. Expect:
  - two valid pulses 8 SCLK periods apart, with data 0x3C then 0xC3;
  - Out_rx_data holding 0xC3 after CS high.
- **Abort:** CS high after 5 bits of 0xFF, following an earlier 0x12. Expect one Out_frame_err pulse, no valid, and Out_rx_data still 0x12.
- **Reset mid-word:** assert In_rst after 3 bits. Expect:
  - all outputs 0 on the next cycle;
  - with CS still low, further SCLK edges produce nothing;
  - a new CS high→low frame carrying 0x81 is received correctly.
- **Edge coincidence:** CS rise coincident with the 8th SCLK fall (synchronised). Expect frame_err with no valid, and the word discarded.
- **DATA_WIDTH=16:** send 0xBEEF. Expect a single valid with 0xBEEF.
